oam_dma_master: RTL

Sprite-RAM DMA bus initiator for the $4014 OAM DMA register. Sits between the CPU core and the memory decoder's CPU-side bus. It passes CPU traffic through when idle. On a CPU write to $4014 it stalls the CPU and takes the bus, copying 256 bytes from CPU page `$XX00–$XXFF` into sprite RAM by issuing alternating reads of CPU memory and writes to $2004.

---
 rtl/nes_mem_pkg.sv | 15 +
 rtl/oam_dma_master.sv | 133 +++++++++++++
 2 files changed

// File: rtl/nes_mem_pkg.sv
// Shared CPU-bus definitions for the memory decoder and the OAM DMA initiator.
package nes_mem_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_ALIGN = 2'd1,
        DMA_READ  = 2'd2,
        DMA_WRITE = 2'd3
    } dma_state_e;

    localparam logic [15:0] PPU_OAM_ADDR_REG = 16'h2003;
    localparam logic [15:0] PPU_OAM_DATA_REG = 16'h2004;
    localparam logic [15:0] APU_OAM_DMA_REG  = 16'h4014;

endpackage

// File: rtl/oam_dma_master.sv
// $4014 sprite DMA bus initiator: passes CPU traffic when idle, otherwise copies one page to $2004.
// Build option OAM_DMA_ALIGN_EN adds the parity-dependent alignment cycles of the console.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// DMA_IDLE  | CPU owns the bus; watch for a write to the trigger register
// DMA_ALIGN | dummy cycle(s) before the first read (OAM_DMA_ALIGN_EN only)
// DMA_READ  | read source byte {page, idx}
// DMA_WRITE | forward the returned byte to the sprite RAM data port
module oam_dma_master
    import nes_mem_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = APU_OAM_DMA_REG,
    parameter logic [15:0] OAM_DATA_ADDR = PPU_OAM_DATA_REG
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_write_en,
    input  logic        cpu_read_en,
    output logic        cpu_stall,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data_out,
    output logic        mem_write_en,
    output logic        mem_read_en,
    input  logic [7:0]  mem_data_in,
    output logic        dma_busy
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] rd_data_q, rd_data_d;
`ifdef OAM_DMA_ALIGN_EN
    logic parity_q, parity_d;
    logic extra_q, extra_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DMA_IDLE;
            page_q    <= 8'h00;
            idx_q     <= 8'h00;
            rd_data_q <= 8'h00;
`ifdef OAM_DMA_ALIGN_EN
            parity_q  <= 1'b0;
            extra_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            rd_data_q <= rd_data_d;
`ifdef OAM_DMA_ALIGN_EN
            parity_q  <= parity_d;
            extra_q   <= extra_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        idx_d        = idx_q;
        rd_data_d    = rd_data_q;
`ifdef OAM_DMA_ALIGN_EN
        parity_d     = ~parity_q;
        extra_d      = extra_q;
`endif
        mem_addr     = cpu_addr;
        mem_data_out = cpu_data_in;
        mem_write_en = cpu_write_en;
        mem_read_en  = cpu_read_en;

        case (state_q)
            DMA_IDLE: begin
                // The trigger write itself still reaches the decoder.
                if (cpu_write_en && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d  = cpu_data_in;
                    idx_d   = 8'h00;
`ifdef OAM_DMA_ALIGN_EN
                    extra_d = parity_q;
                    state_d = DMA_ALIGN;
`else
                    state_d = DMA_READ;
`endif
                end
            end
            DMA_ALIGN: begin
                mem_addr     = 16'h0000;
                mem_data_out = 8'h00;
                mem_write_en = 1'b0;
                mem_read_en  = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
                if (extra_q) begin
                    extra_d = 1'b0;
                end else begin
                    state_d = DMA_READ;
                end
`else
                state_d = DMA_IDLE;
`endif
            end
            DMA_READ: begin
                mem_addr     = {page_q, idx_q};
                mem_data_out = 8'h00;
                mem_write_en = 1'b0;
                mem_read_en  = 1'b1;
                state_d      = DMA_WRITE;
            end
            DMA_WRITE: begin
                // Decoder returns read data one cycle after the strobe.
                mem_addr     = OAM_DATA_ADDR;
                mem_data_out = mem_data_in;
                mem_write_en = 1'b1;
                mem_read_en  = 1'b0;
                rd_data_d    = mem_data_in;
                if (idx_q == 8'hFF) begin
                    state_d = DMA_IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = DMA_READ;
                end
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    assign cpu_stall = (state_q != DMA_IDLE);
    assign dma_busy  = (state_q != DMA_IDLE);

endmodule
